// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the instruction encoder: major opcodes,
// command classes, encoder FSM states and the canonical NOP word.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // funct7 used by sub / sra / srai
    localparam logic [6:0] F7_ALT = 7'b0100000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [3:0] {
        CLS_LOAD   = 4'd0,
        CLS_STORE  = 4'd1,
        CLS_RTYPE  = 4'd2,
        CLS_BRANCH = 4'd3,
        CLS_ITYPE  = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8
    } cmd_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I field packer: turns a command class plus register,
// funct and immediate fields into a 32-bit instruction word. Flags classes
// outside the decoded opcode set. When ENC_CHECK_EN is defined it also
// reports fields that would not survive encoding (out-of-range or odd
// immediates, funct3 values with no meaning for the class).
module instr_field_pack
    import rv_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        chk_fail
);

    logic       is_shift;
    logic [6:0] f7;

    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign f7       = alt ? F7_ALT : 7'b0000000;

    // Pack the fields in the instruction format selected by the class
    always_comb begin
        word    = NOP_INSN;
        illegal = 1'b0;
        case (cls)
            CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            CLS_RTYPE:  word = {f7, rs2, rs1, funct3, rd, OP_OP};
            CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                                imm[4:1], imm[11], OP_BRANCH};
            CLS_ITYPE: begin
                if (is_shift)
                    word = {f7, imm[4:0], rs1, funct3, rd, OP_IMM};
                else
                    word = {imm[11:0], rs1, funct3, rd, OP_IMM};
            end
            CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            CLS_JALR:   word = {imm[11:0], rs1, funct3, rd, OP_JALR};
            CLS_LUI:    word = {imm[31:12], rd, OP_LUI};
            CLS_AUIPC:  word = {imm[31:12], rd, OP_AUIPC};
            default:    illegal = 1'b1;
        endcase
    end

`ifdef ENC_CHECK_EN
    logic fit12;
    logic fit13;
    logic fit21;

    // A value fits N signed bits when everything above bit N-2 is a copy of the sign
    assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

    // Reject fields the chosen format would silently truncate or misinterpret
    always_comb begin
        chk_fail = 1'b0;
        case (cls)
            CLS_LOAD:   chk_fail = ~fit12 | (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
            CLS_STORE:  chk_fail = ~fit12 | funct3[2] | (funct3[1:0] == 2'b11);
            CLS_BRANCH: chk_fail = ~fit13 | imm[0] | (funct3[2:1] == 2'b01);
            CLS_ITYPE:  chk_fail = ~fit12 | (is_shift & (|imm[11:5]));
            CLS_JAL:    chk_fail = ~fit21 | imm[0];
            CLS_JALR:   chk_fail = ~fit12 | (funct3 != 3'b000);
            CLS_LUI,
            CLS_AUIPC:  chk_fail = |imm[11:0];
            default:    chk_fail = 1'b0;
        endcase
    end
`else
    assign chk_fail = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I instruction encoder / program loader. Accepts field-level
// commands over valid/ready, packs them through instr_field_pack and writes
// the resulting words to consecutive instruction-memory addresses through a
// single output register.
// Optional build macro: ENC_CHECK_EN enables per-command field checking.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int          ADDR_W    = 11,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [3:0]        cmd_class_i,
    input  logic [2:0]        cmd_funct3_i,
    input  logic              cmd_alt_i,
    input  logic [4:0]        cmd_rd_i,
    input  logic [4:0]        cmd_rs1_i,
    input  logic [4:0]        cmd_rs2_i,
    input  logic [31:0]       cmd_imm_i,
    input  logic              cmd_last_i,
    output logic              imem_wren_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    input  logic              imem_ready_i,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] BASE_W   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    enc_state_e        state_q;
    enc_state_e        state_d;

    logic              vld_p1;
    logic              last_p1;
    logic [31:0]       wdata_p1;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       pack_word;
    logic              pack_illegal;
    logic              pack_fail;

    logic              at_top;
    logic              ovf_hold;
    logic              wr_hs;
    logic              accept;
    logic              reject;
    logic              take;

    instr_field_pack u_pack (
        .cls      (cmd_class_i),
        .funct3   (cmd_funct3_i),
        .alt      (cmd_alt_i),
        .rd       (cmd_rd_i),
        .rs1      (cmd_rs1_i),
        .rs2      (cmd_rs2_i),
        .imm      (cmd_imm_i),
        .word     (pack_word),
        .illegal  (pack_illegal),
        .chk_fail (pack_fail)
    );

    // A non-last word sitting at the top address will overflow when written,
    // so nothing further may be accepted behind it.
    assign at_top   = (addr_q == {ADDR_W{1'b1}});
    assign ovf_hold = vld_p1 & at_top & ~last_p1;
    // A restart discards the pending word rather than completing it
    assign wr_hs    = vld_p1 & imem_ready_i & ~start_i;
    assign accept   = cmd_valid_i & cmd_ready_o;
    assign reject   = accept & (pack_illegal | pack_fail);
    assign take     = accept & ~reject;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: finish on the last word's write, a dropped last
    // command, or an address overflow; start always (re)enters RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN: begin
                if (!start_i) begin
                    if (wr_hs && (last_p1 || at_top)) state_d = ST_DONE;
                    else if (reject && cmd_last_i)    state_d = ST_DONE;
                end
            end
            ST_DONE: if (start_i) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: take a command only while running, not restarting, with
    // room in the output register and no overflow pending
    always_comb begin
        cmd_ready_o = (state_q == ST_RUN) & ~start_i & (~vld_p1 | imem_ready_i) & ~ovf_hold;
    end

    // Output register, write address, word counter and status flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            wdata_p1 <= '0;
            addr_q   <= BASE_W;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (start_i) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            addr_q  <= BASE_W;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // stage boundary: accepted command -> registered memory write
            if (take) begin
                vld_p1   <= 1'b1;
                last_p1  <= cmd_last_i;
                wdata_p1 <= pack_word;
            end else if (wr_hs) begin
                vld_p1 <= 1'b0;
            end
            if (wr_hs) begin
                addr_q <= addr_q + ADDR_ONE;
                cnt_q  <= cnt_q + CNT_ONE;
                if (last_p1)      done_q <= 1'b1;
                else if (at_top)  err_q  <= 1'b1;
            end
            if (reject) begin
                err_q <= 1'b1;
                if (cmd_last_i) done_q <= 1'b1;
            end
        end
    end

    assign imem_wren_o  = vld_p1;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_p1;
    assign word_cnt_o   = cnt_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. A default-size instance carries most
// scenarios; a second instance with a 4-word memory exercises overflow.
// Written words are matched against a scoreboard of expected address/data.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic        rdy;
    logic [3:0]  cls = '0;
    logic [2:0]  f3 = '0;
    logic        alt = 1'b0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;
    logic        last = 1'b0;
    logic        wren;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic        imem_ready = 1'b1;
    logic [11:0] cnt;
    logic        done;
    logic        err;

    logic        start2 = 1'b0;
    logic        valid2 = 1'b0;
    logic        rdy2;
    logic        wren2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  cnt2;
    logic        done2;
    logic        err2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [10:0] exp_addr = '0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(11), .BASE_ADDR(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .cmd_valid_i(valid), .cmd_ready_o(rdy),
        .cmd_class_i(cls), .cmd_funct3_i(f3), .cmd_alt_i(alt),
        .cmd_rd_i(rd), .cmd_rs1_i(rs1), .cmd_rs2_i(rs2),
        .cmd_imm_i(imm), .cmd_last_i(last),
        .imem_wren_o(wren), .imem_addr_o(addr), .imem_wdata_o(wdata),
        .imem_ready_i(imem_ready), .word_cnt_o(cnt),
        .done_o(done), .err_o(err)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start2),
        .cmd_valid_i(valid2), .cmd_ready_o(rdy2),
        .cmd_class_i(cls), .cmd_funct3_i(f3), .cmd_alt_i(alt),
        .cmd_rd_i(rd), .cmd_rs1_i(rs1), .cmd_rs2_i(rs2),
        .cmd_imm_i(imm), .cmd_last_i(last),
        .imem_wren_o(wren2), .imem_addr_o(addr2), .imem_wdata_o(wdata2),
        .imem_ready_i(imem_ready), .word_cnt_o(cnt2),
        .done_o(done2), .err_o(err2)
    );

    // Reference encoder: returns {reject, word}
    function automatic logic [32:0] model(input logic [3:0] c, input logic [2:0] f,
                                          input logic a, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [31:0] im);
        logic [31:0] w;
        logic        bad;
        int          v;
        logic [31:0] base;
        v    = int'(im);
        base = (32'(d) << 7) | (32'(f) << 12) | (32'(s1) << 15);
        w    = 32'h0000_0013;
        bad  = 1'b0;
        case (c)
            4'd0: begin
                w   = 32'h03 | base | (im << 20);
                bad = (v < -2048) || (v > 2047) || (f == 3) || (f == 6) || (f == 7);
            end
            4'd1: begin
                w   = 32'h23 | (32'(im[4:0]) << 7) | (32'(f) << 12) | (32'(s1) << 15)
                      | (32'(s2) << 20) | (32'(im[11:5]) << 25);
                bad = (v < -2048) || (v > 2047) || (f > 2);
            end
            4'd2: begin
                w = 32'h33 | base | (32'(s2) << 20) | (a ? 32'h4000_0000 : 32'h0);
            end
            4'd3: begin
                w   = 32'h63 | (32'(im[11]) << 7) | (32'(im[4:1]) << 8) | (32'(f) << 12)
                      | (32'(s1) << 15) | (32'(s2) << 20) | (32'(im[10:5]) << 25)
                      | (32'(im[12]) << 31);
                bad = (v < -4096) || (v > 4095) || im[0] || (f == 2) || (f == 3);
            end
            4'd4: begin
                if (f == 1 || f == 5) begin
                    w   = 32'h13 | base | (32'(im[4:0]) << 20) | (a ? 32'h4000_0000 : 32'h0);
                    bad = (v < 0) || (v > 31);
                end else begin
                    w   = 32'h13 | base | (im << 20);
                    bad = (v < -2048) || (v > 2047);
                end
            end
            4'd5: begin
                w   = 32'h6F | (32'(d) << 7) | (32'(im[19:12]) << 12) | (32'(im[11]) << 20)
                      | (32'(im[10:1]) << 21) | (32'(im[20]) << 31);
                bad = (v < -1048576) || (v > 1048575) || im[0];
            end
            4'd6: begin
                w   = 32'h67 | base | (im << 20);
                bad = (v < -2048) || (v > 2047) || (f != 0);
            end
            4'd7: begin
                w   = 32'h37 | (32'(d) << 7) | (im & 32'hFFFF_F000);
                bad = (im & 32'h0000_0FFF) != 0;
            end
            4'd8: begin
                w   = 32'h17 | (32'(d) << 7) | (im & 32'hFFFF_F000);
                bad = (im & 32'h0000_0FFF) != 0;
            end
            default: bad = 1'b1;
        endcase
`ifndef ENC_CHECK_EN
        if (c <= 4'd8) bad = 1'b0;
`endif
        return {bad, w};
    endfunction

    // Scoreboard: every write handshake on the main instance must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && wren && imem_ready && !start) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_write: unexpected write addr %0d data %h, none required", addr, wdata);
            end else begin
                e = sbq.pop_front();
                if (addr !== e.addr || wdata !== e.data) begin
                    errors++;
                    $display("FAIL sb_write: got addr %0d data %h, required addr %0d data %h",
                             addr, wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sbq.delete();
        exp_addr = '0;
    endtask

    // Present one command and wait (bounded) for acceptance; valid stays high on return
    task automatic send(input logic [3:0] c, input logic [2:0] f, input logic a,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im, input logic l);
        logic [32:0] m;
        bit ok;
        cls = c; f3 = f; alt = a; rd = d; rs1 = s1; rs2 = s2; imm = im; last = l;
        valid = 1'b1;
        m = model(c, f, a, d, s1, s2, im);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1;
                if (!m[32]) begin
                    sbq.push_back({exp_addr, m[31:0]});
                    exp_addr = exp_addr + 11'd1;
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: cmd_ready never high for class %0d, required 1", c);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (rdy !== 1'b0 || wren !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy %b wren %b done %b err %b, required all 0", rdy, wren, done, err);
        end
        checks++;
        if (addr !== 11'd0 || wdata !== 32'd0 || cnt !== 12'd0) begin
            errors++;
            $display("FAIL reset_data: addr %0d wdata %h cnt %0d, required 0 0 0", addr, wdata, cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_itype();
        do_start();
        send(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wren !== 1'b1 || addr !== 11'd0 || wdata !== 32'h0050_0093) begin
            errors++;
            $display("FAIL itype_latency: wren %b addr %0d wdata %h, required 1 0 00500093", wren, addr, wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_formats();
        send(4'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wdata !== 32'h4020_81B3) begin
            errors++;
            $display("FAIL rtype_sub: wdata %h, required 402081b3", wdata);
        end
        @(posedge clk); #1;
        send(4'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wdata !== 32'hFE20_8EE3) begin
            errors++;
            $display("FAIL branch_neg: wdata %h, required fe208ee3", wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        do_start();
        imem_ready = 1'b0;
        send(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wren !== 1'b1 || addr !== 11'd0 || wdata !== 32'h0080_00EF || rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: wren %b addr %0d wdata %h rdy %b, required 1 0 008000ef 0",
                         wren, addr, wdata, rdy);
            end
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_early: done %b during handshake, required 0", done);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cnt !== 12'd1 || wren !== 1'b0 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL done_after: done %b cnt %0d wren %b rdy %b, required 1 1 0 0", done, cnt, wren, rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        do_start();
        send(4'd12, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wren !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_class: wren %b err %b, required 0 1", wren, err);
        end
        @(posedge clk); #1;
        do_start();
        send(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        valid = 1'b0;
        @(negedge clk);
        checks++;
`ifdef ENC_CHECK_EN
        if (wren !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL imm_range: wren %b err %b, required 0 1", wren, err);
        end
`else
        if (wren !== 1'b1 || wdata !== 32'h8000_0093 || err !== 1'b0) begin
            errors++;
            $display("FAIL imm_trunc: wren %b wdata %h err %b, required 1 80000093 0", wren, wdata, err);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  c;
        logic [31:0] im;
        int          r;
        int          n;
        do_start();
        imem_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            c = 4'($urandom_range(0, 8));
            r = int'($urandom_range(0, 16383)) - 8192;
            im = 32'(r);
            if (c >= 4'd7 && $urandom_range(0, 1) == 1) im = $urandom() & 32'hFFFF_F000;
            if (!model(c, 3'($urandom_range(0, 7)), 1'b0, 5'd0, 5'd0, 5'd0, im)[32]) n++;
            send(c, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), im, 1'b0);
        end
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (cnt !== 12'(exp_addr) || sbq.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: cnt %0d pending %0d, required %0d 0", cnt, sbq.size(), exp_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_restart();
        do_start();
        imem_ready = 1'b1;
        send(4'd4, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0);
        valid = 1'b0;
        @(posedge clk); #1;
        send(4'd13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        valid = 1'b0;
        imem_ready = 1'b0;
        send(4'd4, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd9, 1'b0);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b0 || err !== 1'b1 || wren !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre: rdy %b err %b wren %b, required 0 1 1", rdy, err, wren);
        end
        @(posedge clk); #1;
        start = 1'b0;
        valid = 1'b0;
        sbq.delete();
        exp_addr = '0;
        @(negedge clk);
        checks++;
        if (wren !== 1'b0 || addr !== 11'd0 || cnt !== 12'd0 || err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: wren %b addr %0d cnt %0d err %b done %b, required 0 0 0 0 0",
                     wren, addr, cnt, err, done);
        end
        @(posedge clk); #1;
        imem_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        do_start();
        imem_ready = 1'b0;
        send(4'd4, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'd3, 1'b0);
        valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wren !== 1'b0 || addr !== 11'd0 || wdata !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: wren %b addr %0d wdata %h, required 0 0 0", wren, addr, wdata);
        end
        sbq.delete();
        exp_addr = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_ready = 1'b1;
    endtask

    task automatic test_overflow();
        int acc;
        int wr;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cls = 4'd4; f3 = 3'd0; alt = 1'b0; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd1; last = 1'b0;
        imem_ready = 1'b1;
        valid2 = 1'b1;
        acc = 0;
        wr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rdy2) acc++;
            if (wren2) begin
                checks++;
                if (addr2 !== 2'(wr) || wdata2 !== 32'h0010_0093) begin
                    errors++;
                    $display("FAIL ovf_write: addr %0d wdata %h, required %0d 00100093", addr2, wdata2, wr);
                end
                wr++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (acc != 4 || wr != 4) begin
            errors++;
            $display("FAIL ovf_count: accepted %0d written %0d, required 4 4", acc, wr);
        end
        checks++;
        if (err2 !== 1'b1 || cnt2 !== 3'd4 || rdy2 !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_state: err %b cnt %0d rdy %b done %b, required 1 4 0 0", err2, cnt2, rdy2, done2);
        end
        @(posedge clk); #1;
        valid2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_itype();
        test_formats();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_restart();
        test_async_reset();
        test_overflow();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d writes outstanding, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
